led_chaser: RTL and testbench



---
 rtl/led_chaser.sv | 62 ++++++
 tb/tb_led_chaser.sv | 124 ++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// Single-lit "flowing light" driver for a 4-LED bank. A prescaler emits a step
// every TICK_DIV clocks. On each step the lit LED rotates left or ping-pongs between the ends.
module led_chaser #(
  parameter int unsigned TICK_DIV  = 32'd12_500_000,
  parameter bit          PING_PONG = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] leds
);

  localparam int unsigned   CW   = (TICK_DIV <= 32'd1) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'd1);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  dir_t          dir;
  dir_t          next_dir;
  logic [CW-1:0] count;
  logic          step;
  logic          one_hot;
  logic [3:0]    next_leds;

  assign step    = (count == LAST);
  assign one_hot = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);

  // Any corrupted pattern falls back to the reset state on the next step.
  always_comb begin
    next_leds = 4'b0001;
    next_dir  = DIR_LEFT;
    if (one_hot) begin
      if (!PING_PONG) begin
        next_leds = {leds[2:0], leds[3]};
        next_dir  = DIR_LEFT;
      end else if (leds[0] || (dir == DIR_LEFT && !leds[3])) begin
        next_leds = leds << 1;
        next_dir  = next_leds[3] ? DIR_RIGHT : DIR_LEFT;
      end else begin
        next_leds = leds >> 1;
        next_dir  = next_leds[0] ? DIR_LEFT : DIR_RIGHT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      leds  <= 4'b0001;
      dir   <= DIR_LEFT;
    end else begin
      count <= step ? '0 : count + CW'(1);
      if (step) begin
        leds <= next_leds;
        dir  <= next_dir;
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Randomised scoreboard bench for led_chaser across several TICK_DIV / PING_PONG
// configurations sharing one clock and reset.
module tb_led_chaser;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  leds_rot4, leds_pp4, leds_rot1, leds_def, leds_pp3;
  logic [19:0] leds_all;

  logic [19:0] exp_q[$];
  int unsigned k;
  int          tests = 0;
  int          fails = 0;

  always #10 clk = ~clk;

  led_chaser #(.TICK_DIV(4), .PING_PONG(1'b0)) u_rot4 (.clk(clk), .rst_n(rst_n), .leds(leds_rot4));
  led_chaser #(.TICK_DIV(4), .PING_PONG(1'b1)) u_pp4  (.clk(clk), .rst_n(rst_n), .leds(leds_pp4));
  led_chaser #(.TICK_DIV(1), .PING_PONG(1'b0)) u_rot1 (.clk(clk), .rst_n(rst_n), .leds(leds_rot1));
  led_chaser                                   u_def  (.clk(clk), .rst_n(rst_n), .leds(leds_def));
  led_chaser #(.TICK_DIV(3), .PING_PONG(1'b1)) u_pp3  (.clk(clk), .rst_n(rst_n), .leds(leds_pp3));

  assign leds_all = {leds_pp3, leds_def, leds_rot1, leds_pp4, leds_rot4};

  function automatic int unsigned div_of(int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 1;
      3: return 12_500_000;
      default: return 3;
    endcase
  endfunction

  function automatic bit pp_of(int i);
    return (i == 1) || (i == 4);
  endfunction

  // Reference: after k counted edges, the light has taken k/TICK_DIV steps.
  function automatic logic [3:0] exp_leds(int i, int unsigned edges);
    int unsigned steps;
    int unsigned pos;
    steps = edges / div_of(i);
    if (pp_of(i)) begin
      pos = steps % 6;
      if (pos > 3) pos = 6 - pos;
    end else begin
      pos = steps % 4;
    end
    return 4'(1 << pos);
  endfunction

  function automatic logic [19:0] exp_all(int unsigned edges);
    logic [19:0] e;
    for (int i = 0; i < N; i++) e[4*i +: 4] = exp_leds(i, edges);
    return e;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: leds {pp3,def,rot1,pp4,rot4}=%h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) k++;
      exp_q.push_back(exp_all(k));
    end
  endtask

  // 5 ns reset pulse placed between edges; reset must act without a clock.
  task automatic pulse_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    k = 0;
    #1 check("async_reset", leds_all, exp_all(0));
    #4 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", leds_all, exp_q.pop_front());
  end

  initial begin
    rst_n = 1'b0;
    k = 0;
    run_cycles(5);
    #10 rst_n = 1'b1;
    run_cycles(100);

    // Reset while rot4 shows 0100, then confirm the prescaler restarts.
    pulse_reset();
    run_cycles(9);
    check("rot4_at_0100", {16'd0, leds_rot4}, {16'd0, 4'b0100});
    pulse_reset();
    run_cycles(12);

    repeat (8) begin
      run_cycles(int'($urandom_range(1, 70)));
      pulse_reset();
    end
    run_cycles(30);
    @(negedge clk);
    #1 check("queue_drained", 20'(exp_q.size()), 20'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    fails++;
    $display("FAIL watchdog at %0t: run still active, required finished", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
